// File: rtl/handshake_const_compare.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : handshake_const_compare
//  Purpose  : Consumer end of a handshake-constant channel. Each accepted
//             token is compared with CONST_VALUE; the 1-bit result is queued
//             in a 2-entry FIFO. Saturating match/mismatch counters and a
//             sticky error flag track the comparison history.
//  Revision : 1.0  initial release
// ============================================================================
module handshake_const_compare #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(19'b0100110000011100110),
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  sticky_error
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [1:0]           c_depth   = 2'd2;

  // FIFO storage and bookkeeping
  logic [1:0]           mem_q, mem_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           occ_q, occ_d;

  // Statistics
  logic [CNT_WIDTH-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_WIDTH-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic                 sticky_q, sticky_d;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_match;

  // Ready depends only on occupancy and reset, never on outs_ready.
  assign ins_ready      = ~rst & (occ_q != c_depth);
  assign outs_valid     = (occ_q != 2'd0);
  // Head entry is masked so a stale slot never shows when the FIFO is empty.
  assign outs           = outs_valid & mem_q[rd_ptr_q];
  assign match_count    = match_cnt_q;
  assign mismatch_count = mismatch_cnt_q;
  assign sticky_error   = sticky_q;

  assign w_push  = ins_valid & ins_ready;
  assign w_pop   = outs_valid & outs_ready;
  assign w_match = (ins == CONST_VALUE);

  // Next-state for FIFO pointers, occupancy, counters and sticky flag.
  always_comb begin
    mem_d          = mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    occ_d          = occ_q;
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    sticky_d       = sticky_q;

    if (w_push) begin
      mem_d[wr_ptr_q] = w_match;
      wr_ptr_d        = ~wr_ptr_q;
      if (w_match) begin
        if (match_cnt_q != c_cnt_max) begin
          match_cnt_d = match_cnt_q + 1'b1;
        end
      end else begin
        if (mismatch_cnt_q != c_cnt_max) begin
          mismatch_cnt_d = mismatch_cnt_q + 1'b1;
        end
        sticky_d = 1'b1;
      end
    end

    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State register; reset discards queued results immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q          <= 2'b00;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      sticky_q       <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      occ_q          <= occ_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      sticky_q       <= sticky_d;
    end
  end

endmodule
`default_nettype wire
